// File: rtl/ahb_master_busreq.sv
`timescale 1ns/1ps
// Purpose : AHB-style bus master. It requests the bus, issues an INCR burst of
//           1..16 word beats, and recovers from RETRY/SPLIT/ERROR responses.
// Latency : the first NONSEQ appears the cycle after the grant edge. done or
//           error pulses one cycle after the closing response edge.
// Backpressure: HREADY=0 holds HADDR/HTRANS. Losing HGRANT returns the block
//           to REQ without counting the unaccepted beat.
// Ports   : HCLK/HRESET (sync, active-high); start/lock_req/beats/addr_base
//           launch a transaction; HGRANT/HREADY/HRESP come from the bus;
//           HBUSREQ/HLOCK/HTRANS/HADDR go to the bus; busy/done/error report status.
module ahb_master_busreq (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        lock_req,
  input  logic [4:0]  beats,
  input  logic [31:0] addr_base,
  input  logic        HGRANT,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  output logic        HBUSREQ,
  output logic        HLOCK,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_BURST, S_LAST, S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;        // next address to present
  logic [31:0] dp_addr_q, dp_addr_d;  // address of the beat in its data phase
  logic [4:0]  rem_q, rem_d;          // beats whose address is not yet accepted
  logic        lock_q, lock_d;
  logic        abort_q, abort_d;      // RECOVER is finishing an ERROR, not a RETRY
  logic        done_d, error_d;
  logic [1:0]  htrans_d;
  logic        hbusreq_q, hlock_q, busy_q, done_q, error_q;
  logic [1:0]  htrans_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dp_addr_d = dp_addr_q;
    rem_d     = rem_q;
    lock_d    = lock_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start arriving alongside the done pulse belongs to the old transaction.
        if (start && !done_q) begin
          lock_d  = lock_req;
          addr_d  = addr_base;
          abort_d = 1'b0;
          if (beats == 5'd0)       rem_d = 5'd1;
          else if (beats > 5'd16)  rem_d = 5'd16;
          else                     rem_d = beats;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (HGRANT && HREADY) state_d = S_ADDR;
      end

      S_ADDR, S_BURST: begin
        // Only BURST has an earlier beat in its data phase that can be answered.
        if (state_q == S_BURST && !HREADY && HRESP != RESP_OKAY) begin
          state_d = S_RECOVER;
          if (HRESP == RESP_ERROR) begin
            abort_d = 1'b1;
          end else begin
            // Rewind to the failing beat. The current address beat was not accepted.
            addr_d = dp_addr_q;
            rem_d  = rem_q + 5'd1;
          end
        end else if (HREADY) begin
          if (!HGRANT) begin
            state_d = S_REQ;
          end else begin
            dp_addr_d = addr_q;
            addr_d    = addr_q + 32'd4;
            rem_d     = (rem_q != 5'd0) ? rem_q - 5'd1 : 5'd0;
            state_d   = (rem_q == 5'd1) ? S_LAST : S_BURST;
          end
        end
      end

      S_LAST: begin
        if (!HREADY && HRESP != RESP_OKAY) begin
          state_d = S_RECOVER;
          if (HRESP == RESP_ERROR) begin
            abort_d = 1'b1;
          end else begin
            addr_d = dp_addr_q;
            rem_d  = rem_q + 5'd1;
          end
        end else if (HREADY) begin
          // A single-cycle non-OKAY response is treated as an abort so the block cannot hang.
          state_d = S_IDLE;
          rem_d   = 5'd0;
          if (HRESP == RESP_OKAY) done_d  = 1'b1;
          else                    error_d = 1'b1;
        end
      end

      S_RECOVER: begin
        if (HREADY) begin
          if (abort_q) begin
            state_d = S_IDLE;
            rem_d   = 5'd0;
            abort_d = 1'b0;
            error_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ADDR)       htrans_d = TR_NONSEQ;
    else if (state_d == S_BURST) htrans_d = TR_SEQ;
    else                         htrans_d = TR_IDLE;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      dp_addr_q <= '0;
      rem_q     <= '0;
      lock_q    <= 1'b0;
      abort_q   <= 1'b0;
      hbusreq_q <= 1'b0;
      hlock_q   <= 1'b0;
      htrans_q  <= TR_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dp_addr_q <= dp_addr_d;
      rem_q     <= rem_d;
      lock_q    <= lock_d;
      abort_q   <= abort_d;
      hbusreq_q <= (state_d != S_IDLE);
      hlock_q   <= (state_d != S_IDLE) && lock_d;
      htrans_q  <= htrans_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign HBUSREQ = hbusreq_q;
  assign HLOCK   = hlock_q;
  assign HTRANS  = htrans_q;
  assign HADDR   = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_ahb_master_busreq.sv
`timescale 1ns/1ps
// Purpose : directed bench for ahb_master_busreq; hand-derived per-cycle vectors.
// Latency : outputs are sampled 1 ns after each rising edge, and inputs change there too.
// Backpressure: HREADY/HGRANT/HRESP patterns are scripted per scenario.
module tb_ahb_master_busreq;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET, start, lock_req, HGRANT, HREADY;
  logic [4:0]  beats;
  logic [31:0] addr_base;
  logic [1:0]  HRESP;
  logic        HBUSREQ, HLOCK, busy, done, error;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;

  int checks = 0;
  int errors = 0;

  ahb_master_busreq dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .lock_req(lock_req),
    .beats(beats), .addr_base(addr_base), .HGRANT(HGRANT), .HREADY(HREADY),
    .HRESP(HRESP), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HADDR(HADDR), .busy(busy), .done(done), .error(error)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Starts a transaction; returns in the first address-phase cycle (grant held high).
  task automatic launch(input logic [4:0] b, input logic [31:0] a, input logic l);
    start = 1'b1; beats = b; addr_base = a; lock_req = l;
    HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    HRESET = 1'b1; start = 1'b0; lock_req = 1'b0; beats = 5'd0; addr_base = 32'h0;
    HGRANT = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    tick(); tick();
    checks++;
    if ({HBUSREQ, HLOCK, HTRANS, busy, done, error} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {HBUSREQ, HLOCK, HTRANS, busy, done, error});
    end
    checks++;
    if (HADDR !== 32'h0) begin
      errors++;
      $display("FAIL reset_haddr: got %h want 00000000", HADDR);
    end
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    launch(5'd1, 32'h100, 1'b0);
    checks++;
    if (HTRANS !== NSQ || HADDR !== 32'h100 || HBUSREQ !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_nonseq: HTRANS=%b HADDR=%h req=%b busy=%b want 10 00000100 1 1", HTRANS, HADDR, HBUSREQ, busy);
    end
    tick();
    checks++;
    if (HTRANS !== IDL || done !== 1'b0 || HBUSREQ !== 1'b1) begin
      errors++;
      $display("FAIL single_last: HTRANS=%b done=%b req=%b want 00 0 1", HTRANS, done, HBUSREQ);
    end
    tick();
    checks++;
    if (done !== 1'b1 || HBUSREQ !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b req=%b busy=%b want 1 0 0", done, HBUSREQ, busy);
    end
    // start during the done pulse must be ignored
    start = 1'b1; beats = 5'd1; addr_base = 32'h900;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || HBUSREQ !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done: busy=%b req=%b done=%b want 0 0 0", busy, HBUSREQ, done);
    end
    tick();
  endtask

  task automatic test_burst_locked();
    launch(5'd4, 32'h200, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (HTRANS !== ((k == 0) ? NSQ : SQ) || HADDR !== 32'h200 + 32'(4 * k) || HLOCK !== 1'b1) begin
        errors++;
        $display("FAIL locked_beat%0d: HTRANS=%b HADDR=%h HLOCK=%b want %b %h 1",
                 k, HTRANS, HADDR, HLOCK, (k == 0) ? NSQ : SQ, 32'h200 + 32'(4 * k));
      end
      // start outside IDLE must have no effect
      if (k > 0) begin start = 1'b1; addr_base = 32'hDEAD0000; end
      tick();
    end
    start = 1'b0;
    checks++;
    if (HTRANS !== IDL || HLOCK !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL locked_last: HTRANS=%b HLOCK=%b done=%b want 00 1 0", HTRANS, HLOCK, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || HLOCK !== 1'b0 || HBUSREQ !== 1'b0) begin
      errors++;
      $display("FAIL locked_done: done=%b HLOCK=%b req=%b want 1 0 0", done, HLOCK, HBUSREQ);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL locked_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_wait_states();
    logic [1:0]  t [8];
    logic [31:0] a [8];
    logic        r [8];
    logic        d [8];
    int acc;
    t = '{NSQ, SQ, SQ, SQ, SQ, SQ, IDL, IDL};
    a = '{32'h400, 32'h404, 32'h404, 32'h404, 32'h408, 32'h40C, 32'h0, 32'h0};
    r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    acc = 0;
    launch(5'd4, 32'h400, 1'b0);
    for (int i = 0; i < 8; i++) begin
      HREADY = r[i];
      checks++;
      if (HTRANS !== t[i] || (t[i] != IDL && HADDR !== a[i]) || done !== d[i]) begin
        errors++;
        $display("FAIL wait_c%0d: HTRANS=%b HADDR=%h done=%b want %b %h %b", i + 1, HTRANS, HADDR, done, t[i], a[i], d[i]);
      end
      if (HTRANS != IDL && r[i]) acc++;
      tick();
    end
    HREADY = 1'b1;
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL wait_accepts: got %0d want 4", acc);
    end
  endtask

  task automatic test_retry();
    logic [1:0]  t [10];
    logic [31:0] a [10];
    logic        r [10];
    logic [1:0]  s [10];
    logic [1:0]  q [10];
    t = '{NSQ, SQ, SQ, SQ, IDL, IDL, NSQ, SQ, IDL, IDL};
    a = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h0, 32'h0, 32'h308, 32'h30C, 32'h0, 32'h0};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    s = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    // {HBUSREQ, done}
    q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    launch(5'd4, 32'h300, 1'b0);
    for (int i = 0; i < 10; i++) begin
      HREADY = r[i]; HRESP = s[i];
      checks++;
      if (HTRANS !== t[i] || (t[i] != IDL && HADDR !== a[i]) || {HBUSREQ, done} !== q[i]) begin
        errors++;
        $display("FAIL retry_c%0d: HTRANS=%b HADDR=%h req,done=%b want %b %h %b",
                 i + 1, HTRANS, HADDR, {HBUSREQ, done}, t[i], a[i], q[i]);
      end
      tick();
    end
    HRESP = 2'b00; HREADY = 1'b1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL retry_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_error();
    logic [1:0]  t [6];
    logic [31:0] a [6];
    logic        r [6];
    logic [1:0]  s [6];
    logic [3:0]  q [6];
    t = '{NSQ, SQ, SQ, IDL, IDL, IDL};
    a = '{32'h500, 32'h504, 32'h508, 32'h0, 32'h0, 32'h0};
    r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    // {HBUSREQ, busy, done, error}
    q = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0001, 4'b0000};
    launch(5'd8, 32'h500, 1'b0);
    for (int i = 0; i < 6; i++) begin
      HREADY = r[i]; HRESP = s[i];
      checks++;
      if (HTRANS !== t[i] || (t[i] != IDL && HADDR !== a[i]) || {HBUSREQ, busy, done, error} !== q[i]) begin
        errors++;
        $display("FAIL error_c%0d: HTRANS=%b HADDR=%h req,busy,done,err=%b want %b %h %b",
                 i + 1, HTRANS, HADDR, {HBUSREQ, busy, done, error}, t[i], a[i], q[i]);
      end
      tick();
    end
    HRESP = 2'b00; HREADY = 1'b1;
  endtask

  task automatic test_grant_resume();
    logic [1:0]  t [7];
    logic [31:0] a [7];
    logic        g [7];
    logic [1:0]  q [7];
    t = '{NSQ, SQ, IDL, NSQ, SQ, IDL, IDL};
    a = '{32'h800, 32'h804, 32'h0, 32'h804, 32'h808, 32'h0, 32'h0};
    g = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    launch(5'd3, 32'h800, 1'b0);
    for (int i = 0; i < 7; i++) begin
      HGRANT = g[i];
      checks++;
      if (HTRANS !== t[i] || (t[i] != IDL && HADDR !== a[i]) || {HBUSREQ, done} !== q[i]) begin
        errors++;
        $display("FAIL grant_c%0d: HTRANS=%b HADDR=%h req,done=%b want %b %h %b",
                 i + 1, HTRANS, HADDR, {HBUSREQ, done}, t[i], a[i], q[i]);
      end
      tick();
    end
    HGRANT = 1'b1;
  endtask

  task automatic test_clamp_wrap();
    logic [31:0] seen [16];
    int n;
    logic got;
    for (int i = 0; i < 16; i++) seen[i] = 32'h0;
    // beats=31 clamps to 16; the burst crosses the top of the address space
    launch(5'd31, 32'hFFFF_FFF0, 1'b0);
    n = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (HTRANS != IDL) begin
        if (n < 16) seen[n] = HADDR;
        n++;
      end
      if (done) got = 1'b1;
      else tick();
    end
    tick();
    checks++;
    if (!got || n != 16) begin
      errors++;
      $display("FAIL clamp16: beats issued %0d done=%b want 16 1", n, got);
    end
    checks++;
    if (seen[0] !== 32'hFFFF_FFF0 || seen[4] !== 32'h0 || seen[15] !== 32'h2C) begin
      errors++;
      $display("FAIL wrap_addr: %h %h %h want fffffff0 00000000 0000002c", seen[0], seen[4], seen[15]);
    end
    // beats=0 clamps to 1
    launch(5'd0, 32'hA00, 1'b0);
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (HTRANS != IDL) n++;
      if (done) got = 1'b1;
      else tick();
    end
    tick();
    checks++;
    if (!got || n != 1) begin
      errors++;
      $display("FAIL clamp1: beats issued %0d done=%b want 1 1", n, got);
    end
  endtask

  task automatic test_reset_mid_req();
    launch(5'd6, 32'h600, 1'b1);
    tick();
    tick();
    HGRANT = 1'b0;
    tick();
    checks++;
    if (HTRANS !== IDL || HBUSREQ !== 1'b1 || HLOCK !== 1'b1 || busy !== 1'b1 || HADDR !== 32'h608) begin
      errors++;
      $display("FAIL grant_lost_req: HTRANS=%b req=%b lock=%b busy=%b HADDR=%h want 00 1 1 1 00000608",
               HTRANS, HBUSREQ, HLOCK, busy, HADDR);
    end
    HRESET = 1'b1;
    tick();
    checks++;
    if ({HBUSREQ, HLOCK, HTRANS, busy, done, error} !== 7'b0 || HADDR !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: ctrl=%b HADDR=%h want 0000000 00000000",
               {HBUSREQ, HLOCK, HTRANS, busy, done, error}, HADDR);
    end
    HRESET = 1'b0; HGRANT = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse: done=%b error=%b busy=%b want 0 0 0", done, error, busy);
    end
    launch(5'd2, 32'h700, 1'b0);
    checks++;
    if (HTRANS !== NSQ || HADDR !== 32'h700 || HLOCK !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_nonseq: HTRANS=%b HADDR=%h lock=%b want 10 00000700 0", HTRANS, HADDR, HLOCK);
    end
    tick();
    checks++;
    if (HTRANS !== SQ || HADDR !== 32'h704) begin
      errors++;
      $display("FAIL post_reset_seq: HTRANS=%b HADDR=%h want 11 00000704", HTRANS, HADDR);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || HBUSREQ !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_done: done=%b req=%b want 1 0", done, HBUSREQ);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_burst_locked();
    test_wait_states();
    test_retry();
    test_error();
    test_grant_resume();
    test_clamp_wrap();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
